ttl74x168: RTL and testbench

Synchronous 4-bit up/down decade counter modelled on the SN74LS168. It is the down-counting counterpart of the library's up-only decade counter, and supports countdown timers, borrow chains and bidirectional position counters. It uses active-low count enables and an active-low terminal count, so stages cascade with a single `clk` and no ripple clocking.

---
 rtl/ttl_pkg.sv | 16 +
 rtl/ttl_updown_step.sv | 38 +++
 rtl/ttl74x168.sv | 56 +++++
 tb/tb_ttl74x168.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_pkg.sv
// Shared constants and types for the TTL-style counter family.
// The binary variant is selected with the TTL74X168_BINARY_EN macro in the users of this package.
package ttl_pkg;

    localparam int WIDTH          = 4;
    localparam int DECADE_MODULUS = 10;
    localparam int BINARY_MODULUS = 16;

    typedef logic [WIDTH-1:0] ttl_nibble_t;

    // Highest legal count for a given modulus, as a register-width value.
    function automatic ttl_nibble_t last_state(input int modulus);
        return ttl_nibble_t'(modulus - 1);
    endfunction

endpackage

// File: rtl/ttl_updown_step.sv
// Combinational next-count for one up/down step, including wrap and illegal-state recovery.
// Decade behaviour by default; TTL74X168_BINARY_EN selects plain 4-bit binary wrap.
module ttl_updown_step
    import ttl_pkg::*;
(
    input  ttl_nibble_t q,
    input  logic        up,
    output ttl_nibble_t next_q
);

`ifdef TTL74X168_BINARY_EN
    // Every 4-bit value is legal, so the natural 4-bit wrap is the whole story.
    always_comb begin
        // NOTE: assigning a default first keeps always_comb free of inferred latches.
        next_q = q;
        if (up) begin
            next_q = q + 4'd1;
        end else begin
            next_q = q - 4'd1;
        end
    end
`else
    localparam ttl_nibble_t LAST_DECADE = last_state(DECADE_MODULUS);

    always_comb begin
        next_q = q;
        if (q > LAST_DECADE) begin
            // Codes 10-15 recover in a single enabled edge, towards the end nearest the direction.
            next_q = up ? '0 : LAST_DECADE;
        end else if (up) begin
            next_q = (q == LAST_DECADE) ? '0 : q + 4'd1;
        end else begin
            next_q = (q == '0) ? LAST_DECADE : q - 4'd1;
        end
    end
`endif

endmodule

// File: rtl/ttl74x168.sv
// SN74LS168-style synchronous up/down decade counter with active-low enables and terminal count.
// Defining TTL74X168_BINARY_EN turns it into the SN74LS169 binary (modulo-16) variant.
module ttl74x168
    import ttl_pkg::*;
(
    input  logic             clk,
    input  logic             MR,
    input  logic             PE_n,
    input  logic             CEP_n,
    input  logic             CET_n,
    input  logic             U_D,
    input  logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] Q,
    output logic             TC_n
);

`ifdef TTL74X168_BINARY_EN
    localparam int MODULUS = BINARY_MODULUS;
`else
    localparam int MODULUS = DECADE_MODULUS;
`endif

    localparam ttl_nibble_t TC_UP_VALUE = last_state(MODULUS);

    ttl_nibble_t step_q;

    ttl_updown_step u_step (
        .q      (Q),
        .up     (U_D),
        .next_q (step_q)
    );

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so all flops update together.
        if (MR) begin
            Q <= '0;
        end else if (!PE_n) begin
            Q <= P;
        end else if (!CEP_n && !CET_n) begin
            Q <= step_q;
        end
    end

    // CET_n gates the decode so a stage only signals carry/borrow when the stage below it is at its end.
    always_comb begin
        TC_n = 1'b1;
        if (!CET_n) begin
            if (U_D) begin
                TC_n = (Q != TC_UP_VALUE);
            end else begin
                TC_n = (Q != '0);
            end
        end
    end

endmodule

// File: tb/tb_ttl74x168.sv
// Scoreboard bench for ttl74x168: expected Q values are queued as stimulus is driven, popped after each edge.
// Works in both the decade build and the TTL74X168_BINARY_EN build.
module tb_ttl74x168;

`ifdef TTL74X168_BINARY_EN
    localparam int MODULUS = 16;
`else
    localparam int MODULUS = 10;
`endif

    logic       clk = 1'b0;
    logic       MR, PE_n, CEP_n, CET_n, U_D;
    logic [3:0] P;
    logic [3:0] Q;
    logic       TC_n;

    logic       c_mr, c_ud;
    logic [3:0] lo_q, hi_q;
    logic       lo_tc_n, hi_tc_n;

    int         n_total = 0;
    int         n_pass  = 0;
    int         m_q     = 0;
    logic [3:0] sb[$];
    logic [7:0] sb_casc[$];

    always #5 clk = ~clk;

    ttl74x168 dut (
        .clk(clk), .MR(MR), .PE_n(PE_n), .CEP_n(CEP_n), .CET_n(CET_n),
        .U_D(U_D), .P(P), .Q(Q), .TC_n(TC_n)
    );

    ttl74x168 u_lo (
        .clk(clk), .MR(c_mr), .PE_n(1'b1), .CEP_n(1'b0), .CET_n(1'b0),
        .U_D(c_ud), .P(4'd0), .Q(lo_q), .TC_n(lo_tc_n)
    );

    ttl74x168 u_hi (
        .clk(clk), .MR(c_mr), .PE_n(1'b1), .CEP_n(1'b0), .CET_n(lo_tc_n),
        .U_D(c_ud), .P(4'd0), .Q(hi_q), .TC_n(hi_tc_n)
    );

    // Reference model written as modular arithmetic on integers.
    function automatic int model_next(input int q, input logic mr, input logic pe_n,
                                      input logic cep_n, input logic cet_n, input logic ud,
                                      input logic [3:0] p);
        if (mr) return 0;
        if (!pe_n) return int'(p);
        if (cep_n || cet_n) return q;
        if (q >= MODULUS) return ud ? 0 : MODULUS - 1;
        return ud ? (q + 1) % MODULUS : (q + MODULUS - 1) % MODULUS;
    endfunction

    function automatic logic model_tc_n(input int q, input logic ud, input logic cet_n);
        if (cet_n) return 1'b1;
        if (ud) return (q == MODULUS - 1) ? 1'b0 : 1'b1;
        return (q == 0) ? 1'b0 : 1'b1;
    endfunction

    // Drive one cycle of stimulus, queue the expected Q, and advance past the edge.
    task automatic apply(input logic mr, input logic pe_n, input logic cep_n,
                         input logic cet_n, input logic ud, input logic [3:0] p);
        MR = mr; PE_n = pe_n; CEP_n = cep_n; CET_n = cet_n; U_D = ud; P = p;
        m_q = model_next(m_q, mr, pe_n, cep_n, cet_n, ud, p);
        sb.push_back(m_q[3:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp_q;
        apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
        exp_q = sb.pop_front();
        n_total++;
        if (Q !== exp_q) $display("FAIL reset_q: got %0d expected %0d", Q, exp_q);
        else n_pass++;
        n_total++;
        if (TC_n !== 1'b1) $display("FAIL reset_tc_up: got %b expected 1", TC_n);
        else n_pass++;
        U_D = 1'b0;
        #1;
        n_total++;
        if (TC_n !== 1'b0) $display("FAIL reset_tc_down: got %b expected 0", TC_n);
        else n_pass++;
    endtask

    task automatic test_count_up();
        logic [3:0] exp_q;
        logic       exp_tc;
        for (int i = 0; i < 12; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0);
            exp_q  = sb.pop_front();
            exp_tc = model_tc_n(int'(exp_q), 1'b1, 1'b0);
            n_total++;
            if (Q !== exp_q) $display("FAIL up_q[%0d]: got %0d expected %0d", i, Q, exp_q);
            else n_pass++;
            n_total++;
            if (TC_n !== exp_tc) $display("FAIL up_tc[%0d]: got %b expected %b", i, TC_n, exp_tc);
            else n_pass++;
        end
`ifndef TTL74X168_BINARY_EN
        n_total++;
        if (Q !== 4'd2) $display("FAIL up_final: got %0d expected 2", Q);
        else n_pass++;
`endif
    endtask

    task automatic test_count_down();
        logic [3:0] exp_q;
        logic       exp_tc;
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3);
        exp_q = sb.pop_front();
        n_total++;
        if (Q !== exp_q) $display("FAIL down_load: got %0d expected %0d", Q, exp_q);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
            exp_q  = sb.pop_front();
            exp_tc = model_tc_n(int'(exp_q), 1'b0, 1'b0);
            n_total++;
            if (Q !== exp_q) $display("FAIL down_q[%0d]: got %0d expected %0d", i, Q, exp_q);
            else n_pass++;
            n_total++;
            if (TC_n !== exp_tc) $display("FAIL down_tc[%0d]: got %b expected %b", i, TC_n, exp_tc);
            else n_pass++;
        end
    endtask

    task automatic test_illegal_recovery();
        logic [3:0] loads[2] = '{4'd12, 4'd14};
        logic       dirs[2]  = '{1'b1, 1'b0};
        logic [3:0] exp_q;
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0, dirs[i], loads[i]);
            exp_q = sb.pop_front();
            n_total++;
            if (Q !== exp_q) $display("FAIL illegal_load[%0d]: got %0d expected %0d", i, Q, exp_q);
            else n_pass++;
            n_total++;
            if (TC_n !== model_tc_n(int'(exp_q), dirs[i], 1'b0))
                $display("FAIL illegal_tc[%0d]: got %b expected %b", i, TC_n,
                         model_tc_n(int'(exp_q), dirs[i], 1'b0));
            else n_pass++;
            apply(1'b0, 1'b1, 1'b1, 1'b0, dirs[i], 4'd0);
            exp_q = sb.pop_front();
            n_total++;
            if (Q !== exp_q) $display("FAIL illegal_hold[%0d]: got %0d expected %0d", i, Q, exp_q);
            else n_pass++;
            apply(1'b0, 1'b1, 1'b0, 1'b0, dirs[i], 4'd0);
            exp_q = sb.pop_front();
            n_total++;
            if (Q !== exp_q) $display("FAIL illegal_step[%0d]: got %0d expected %0d", i, Q, exp_q);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        logic [3:0] exp_q;
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
        exp_q = sb.pop_front();
        n_total++;
        if (Q !== exp_q) $display("FAIL prio_mr: got %0d expected %0d", Q, exp_q);
        else n_pass++;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
        exp_q = sb.pop_front();
        n_total++;
        if (Q !== exp_q) $display("FAIL prio_load: got %0d expected %0d", Q, exp_q);
        else n_pass++;
    endtask

    task automatic test_enable_gating();
        logic [3:0] exp_q;
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd9);
        void'(sb.pop_front());
        for (int i = 0; i < 2; i++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd0);
            exp_q = sb.pop_front();
            n_total++;
            if (Q !== exp_q) $display("FAIL gate_hold[%0d]: got %0d expected %0d", i, Q, exp_q);
            else n_pass++;
            n_total++;
            if (TC_n !== model_tc_n(int'(exp_q), 1'b1, 1'b0))
                $display("FAIL gate_tc[%0d]: got %b expected %b", i, TC_n,
                         model_tc_n(int'(exp_q), 1'b1, 1'b0));
            else n_pass++;
        end
        CET_n = 1'b1;
        #1;
        n_total++;
        if (TC_n !== 1'b1) $display("FAIL gate_cet_off: got %b expected 1", TC_n);
        else n_pass++;
        // Direction change: load 5, then one enabled down edge.
        apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd5);
        void'(sb.pop_front());
        apply(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        exp_q = sb.pop_front();
        n_total++;
        if (Q !== exp_q) $display("FAIL dir_change: got %0d expected %0d", Q, exp_q);
        else n_pass++;
    endtask

    task automatic test_cascade();
        logic [7:0] exp_pair;
        int         count   = 0;
        int         carries = 0;
        logic [3:0] prev_hi;
        c_mr = 1'b1; c_ud = 1'b1;
        @(posedge clk);
        #1;
        c_mr = 1'b0;
        prev_hi = hi_q;
        for (int i = 0; i < 100; i++) begin
            count = (count + 1) % (MODULUS * MODULUS);
            sb_casc.push_back({4'(count / MODULUS), 4'(count % MODULUS)});
            @(posedge clk);
            #1;
            exp_pair = sb_casc.pop_front();
            n_total++;
            if ({hi_q, lo_q} !== exp_pair)
                $display("FAIL casc_up[%0d]: got %0d:%0d expected %0d:%0d", i, hi_q, lo_q,
                         exp_pair[7:4], exp_pair[3:0]);
            else n_pass++;
            if (hi_q != prev_hi) carries++;
            prev_hi = hi_q;
        end
        n_total++;
        if (carries != 100 / MODULUS) $display("FAIL casc_carries: got %0d expected %0d", carries, 100 / MODULUS);
        else n_pass++;
        c_ud = 1'b0;
        count = (count + MODULUS * MODULUS - 1) % (MODULUS * MODULUS);
        sb_casc.push_back({4'(count / MODULUS), 4'(count % MODULUS)});
        @(posedge clk);
        #1;
        exp_pair = sb_casc.pop_front();
        n_total++;
        if ({hi_q, lo_q} !== exp_pair)
            $display("FAIL casc_down: got %0d:%0d expected %0d:%0d", hi_q, lo_q,
                     exp_pair[7:4], exp_pair[3:0]);
        else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        MR = 1'b0; PE_n = 1'b1; CEP_n = 1'b1; CET_n = 1'b1; U_D = 1'b1; P = 4'd0;
        c_mr = 1'b1; c_ud = 1'b1;
        test_reset();
        test_count_up();
        test_count_down();
        test_illegal_recovery();
        test_priority();
        test_enable_gating();
        test_cascade();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
